// File: rtl/wb_uart_rx.sv
// Wishbone-slave 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling FSM,
// small receive FIFO with sticky overrun/frame-error flags and a level interrupt.
module wb_uart_rx #(
    parameter int WB_DATA_WIDTH = 32,
    parameter int WB_ADDR_WIDTH = 32,
    parameter int CLKS_PER_BIT  = 16,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
    input  logic [3:0]               wb_sel_i,
    input  logic                     wb_we_i,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    output logic                     wb_ack_o,
    output logic [WB_DATA_WIDTH-1:0] wb_data_o,
    input  logic                     uart_rx_i,
    output logic                     rx_irq_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PTR_W = AW + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

    logic             sync1_r;
    logic             rxs_r;
    rx_state_t        state_r;
    logic [CNT_W-1:0] clk_cnt_r;
    logic [2:0]       bit_cnt_r;
    logic [7:0]       shift_r;

    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic             overrun_r;
    logic             frame_err_r;
    logic             irq_en_r;
    logic             ack_r;
    logic [WB_DATA_WIDTH-1:0] rdata_r;
    logic             irq_r;

    logic             bit_tick_s;
    logic             stop_tick_s;
    logic             push_s;
    logic             frame_set_s;
    logic [PTR_W-1:0] level_s;
    logic             empty_s;
    logic             full_s;
    logic             req_s;
    logic [1:0]       reg_sel_s;
    logic             pop_s;
    logic             sts_wr_s;
    logic             ctrl_wr_s;
    logic             accept_s;
    logic             overrun_set_s;
    logic [8:0]       status_s;
    logic [WB_DATA_WIDTH-1:0] read_data_s;
    logic             unused_s;

    assign bit_tick_s    = (clk_cnt_r == CNT_LAST);
    assign stop_tick_s   = (state_r == ST_STOP) && bit_tick_s;
    assign push_s        = stop_tick_s && rxs_r;
    assign frame_set_s   = stop_tick_s && !rxs_r;

    assign level_s       = wr_ptr_r - rd_ptr_r;
    assign empty_s       = (wr_ptr_r == rd_ptr_r);
    assign full_s        = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);

    assign req_s         = wb_cyc_i && wb_stb_i && !ack_r;
    assign reg_sel_s     = wb_addr_i[3:2];
    assign pop_s         = req_s && !wb_we_i && (reg_sel_s == 2'd0) && !empty_s;
    assign sts_wr_s      = req_s && wb_we_i && (reg_sel_s == 2'd1);
    assign ctrl_wr_s     = req_s && wb_we_i && (reg_sel_s == 2'd2);

    // A push into a full FIFO still lands when the same edge pops the head.
    assign accept_s      = push_s && (!full_s || pop_s);
    assign overrun_set_s = push_s && full_s && !pop_s;

    assign status_s      = {5'(level_s), frame_err_r, overrun_r, full_s, !empty_s};

    assign wb_ack_o      = ack_r;
    assign wb_data_o     = rdata_r;
    assign rx_irq_o      = irq_r;

    assign unused_s      = ^{wb_sel_i, wb_addr_i[WB_ADDR_WIDTH-1:4], wb_addr_i[1:0],
                             wb_data_i[WB_DATA_WIDTH-1:4], wb_data_i[1]};

    // Register read multiplexer.
    always_comb begin
        read_data_s = {WB_DATA_WIDTH{1'b0}};
        case (reg_sel_s)
            2'd0: begin
                if (!empty_s) begin
                    read_data_s[8:0] = {1'b1, mem_r[rd_ptr_r[AW-1:0]]};
                end else begin
                    read_data_s[8:0] = 9'd0;
                end
            end
            2'd1:    read_data_s[8:0] = status_s;
            2'd2:    read_data_s[0]   = irq_en_r;
            default: read_data_s      = {WB_DATA_WIDTH{1'b0}};
        endcase
    end

    // Two-flop synchronizer for the asynchronous serial line.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_r <= 1'b1;
            rxs_r   <= 1'b1;
        end else begin
            sync1_r <= uart_rx_i;
            rxs_r   <= sync1_r;
        end
    end

    // Receive FSM: start-bit qualification at mid-bit, then one sample per bit period.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= ST_IDLE;
            clk_cnt_r <= {CNT_W{1'b0}};
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!rxs_r) begin
                        clk_cnt_r <= {CNT_W{1'b0}};
                        bit_cnt_r <= 3'd0;
                        state_r   <= ST_START;
                    end
                end
                ST_START: begin
                    if (clk_cnt_r == CNT_HALF) begin
                        clk_cnt_r <= {CNT_W{1'b0}};
                        bit_cnt_r <= 3'd0;
                        state_r   <= rxs_r ? ST_IDLE : ST_DATA;
                    end else begin
                        clk_cnt_r <= clk_cnt_r + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_tick_s) begin
                        clk_cnt_r <= {CNT_W{1'b0}};
                        shift_r   <= {rxs_r, shift_r[7:1]};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= ST_STOP;
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_tick_s) begin
                        clk_cnt_r <= {CNT_W{1'b0}};
                        state_r   <= rxs_r ? ST_IDLE : ST_BREAK;
                    end else begin
                        clk_cnt_r <= clk_cnt_r + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (rxs_r) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Receive FIFO storage and pointers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (accept_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= shift_r;
                wr_ptr_r                <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
        end
    end

    // Bus acknowledge, read data, sticky flags, control and interrupt.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_r       <= 1'b0;
            rdata_r     <= {WB_DATA_WIDTH{1'b0}};
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
            irq_en_r    <= 1'b0;
            irq_r       <= 1'b0;
        end else begin
            ack_r       <= req_s;
            rdata_r     <= req_s ? read_data_s : {WB_DATA_WIDTH{1'b0}};
            overrun_r   <= overrun_set_s || (overrun_r && !(sts_wr_s && wb_data_i[2]));
            frame_err_r <= frame_set_s || (frame_err_r && !(sts_wr_s && wb_data_i[3]));
            if (ctrl_wr_s) begin
                irq_en_r <= wb_data_i[0];
            end
            irq_r       <= !empty_s && irq_en_r;
        end
    end

endmodule

// File: tb/tb_wb_uart_rx.sv
// Randomized self-checking bench for wb_uart_rx against a queue-based model of the
// register map, FIFO, sticky flags and interrupt.
module tb_wb_uart_rx;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] wb_addr = 32'd0;
    logic [31:0] wb_wdata = 32'd0;
    logic [3:0]  wb_sel = 4'hF;
    logic        wb_we = 1'b0;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_ack;
    logic [31:0] wb_rdata;
    logic        rx = 1'b1;
    logic        irq;

    int tests_run = 0;
    int tests_failed = 0;

    // Behavioural model state
    logic [7:0] q[$];
    logic       m_ov = 1'b0;
    logic       m_fe = 1'b0;
    logic       m_en = 1'b0;

    wb_uart_rx #(.WB_DATA_WIDTH(32), .WB_ADDR_WIDTH(32), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .wb_addr_i(wb_addr), .wb_data_i(wb_wdata), .wb_sel_i(wb_sel),
        .wb_we_i(wb_we), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_ack_o(wb_ack),
        .wb_data_o(wb_rdata), .uart_rx_i(rx), .rx_irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        int n;
        n = q.size();
        return {23'd0, 5'(n), m_fe, m_ov, (n == DEPTH), (n != 0)};
    endfunction

    task automatic bus(input logic [1:0] a, input logic we, input logic [31:0] wd,
                       output logic [31:0] rd);
        bit got_ack;
        got_ack = 1'b0;
        rd = 32'd0;
        @(negedge clk);
        wb_addr = {28'd0, a, 2'b00};
        wb_we = we;
        wb_wdata = wd;
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        for (int k = 0; k < 8 && !got_ack; k++) begin
            @(posedge clk);
            #1;
            if (wb_ack) begin
                got_ack = 1'b1;
                rd = wb_rdata;
            end
        end
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we = 1'b0;
        if (!got_ack) check("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic read_rxdata(input string tag);
        logic [31:0] d, e;
        e = 32'd0;
        if (q.size() != 0) e = {23'd0, 1'b1, q.pop_front()};
        bus(2'd0, 1'b0, 32'd0, d);
        check(tag, d, e);
    endtask

    task automatic read_status(input string tag);
        logic [31:0] d, e;
        e = exp_status();
        bus(2'd1, 1'b0, 32'd0, d);
        check(tag, d, e);
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] wd);
        logic [31:0] d;
        bus(a, 1'b1, wd, d);
        if (a == 2'd1) begin
            if (wd[2]) m_ov = 1'b0;
            if (wd[3]) m_fe = 1'b0;
        end else if (a == 2'd2) begin
            m_en = wd[0];
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        if (stop) begin
            if (q.size() < DEPTH) q.push_back(b);
            else m_ov = 1'b1;
        end else begin
            m_fe = 1'b1;
            repeat (2 * CPB) @(negedge clk);
        end
    endtask

    task automatic check_irq(input string tag);
        repeat (3) @(negedge clk);
        check(tag, {31'd0, irq}, {31'd0, (q.size() != 0) && m_en});
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  b;
        int          act;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_ack", {31'd0, wb_ack}, 32'd0);
        check("rst_data", wb_rdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        read_status("rst_status");

        // Single frame
        send_frame(8'hA5, 1'b1);
        repeat (2) @(negedge clk);
        read_status("single_status");
        read_rxdata("single_rxdata");
        read_status("single_status_empty");

        // Glitch shorter than half a bit
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        read_status("glitch_status");

        // Frame error, W1C, then a good frame
        send_frame(8'h3C, 1'b0);
        read_status("fe_status");
        write_reg(2'd1, 32'h8);
        read_status("fe_cleared");
        send_frame(8'h55, 1'b1);
        repeat (2) @(negedge clk);
        read_rxdata("fe_next_byte");

        // Overrun: five back-to-back frames
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        repeat (2) @(negedge clk);
        read_status("ovr_status");
        for (int i = 0; i < 5; i++) read_rxdata("ovr_rxdata");
        write_reg(2'd1, 32'h4);
        read_status("ovr_cleared");

        // Interrupt enabled: raised after a byte, drops one cycle after the popping read
        write_reg(2'd2, 32'h1);
        bus(2'd2, 1'b0, 32'd0, d);
        check("ctrl_read", d, 32'd1);
        send_frame(8'hC3, 1'b1);
        check_irq("irq_high");
        read_rxdata("irq_rxdata");
        check("irq_still_high_ack", {31'd0, irq}, 32'd1);
        @(posedge clk);
        #1;
        check("irq_low_after", {31'd0, irq}, 32'd0);
        write_reg(2'd2, 32'h0);
        send_frame(8'h3A, 1'b1);
        check_irq("irq_disabled");
        read_rxdata("irq_dis_rxdata");

        // Randomized mix of traffic
        for (int it = 0; it < 40; it++) begin
            act = $urandom_range(0, 9);
            b = 8'($urandom);
            case (act)
                0, 1, 2: send_frame(b, 1'b1);
                3:       send_frame(b, ($urandom_range(0, 3) != 0));
                4, 5:    read_rxdata("rnd_rxdata");
                6:       read_status("rnd_status");
                7:       write_reg(2'd1, {28'd0, b[3:0]});
                8: begin
                    write_reg(2'd2, {31'd0, b[0]});
                    bus(2'd2, 1'b0, 32'd0, d);
                    check("rnd_ctrl", d, {31'd0, m_en});
                end
                default: begin
                    write_reg(2'd3, 32'hFFFF_FFFF);
                    bus(2'd3, 1'b0, 32'd0, d);
                    check("rnd_reg3", d, 32'd0);
                end
            endcase
            check_irq("rnd_irq");
        end

        // Reset mid-frame at data bit 3 with a pending interrupt
        while (q.size() != 0) read_rxdata("drain");
        write_reg(2'd2, 32'h1);
        send_frame(8'h99, 1'b1);
        check_irq("pre_rst_irq");
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = 1'($urandom_range(0, 1));
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ack", {31'd0, wb_ack}, 32'd0);
        check("mid_rst_data", wb_rdata, 32'd0);
        check("mid_rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;
        q.delete();
        m_ov = 1'b0;
        m_fe = 1'b0;
        m_en = 1'b0;
        read_status("post_rst_status");
        bus(2'd2, 1'b0, 32'd0, d);
        check("post_rst_ctrl", d, 32'd0);
        send_frame(8'h7E, 1'b1);
        repeat (2) @(negedge clk);
        read_status("post_rst_frame_status");
        read_rxdata("post_rst_rxdata");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
